sdram_resp_bram: RTL and testbench
==================================

Name: sdram_resp_bram

Overview:
- Responder side of the SDRAM request interface: accepts RD/WE requests on the SDRAM_* port bundle and serves them from an internal block-RAM word array.
- Ready/data timing matches the MiSTer SDRAM controller, so memory initiators can be simulated, or run on small configurations, without external SDRAM.
- Sits in the SDRAM_CLK domain, in place of the SDRAM controller.
- Optionally emulates periodic refresh stalls, gated by SDRAM_CLKREF.

Parameters:
- AW, 16: word-address width; array depth is 2**AW 32-bit words.
- RD_LAT, 4: cycles from read accept to RD_RDY re-assertion with data; legal range 2..15.
- WR_LAT, 2: cycles from write accept to WE_RDY re-assertion; legal range 2..15.
- REF_PERIOD, 780: cycles between refresh requests; used only with the refresh feature.
- REF_CYCLES, 8: length of each refresh stall, in cycles; used only with the refresh feature.

Ports:
- SDRAM_CLK  in  1  sole clock.
- SDRAM_RESn  in  1  synchronous active-low reset.
- SDRAM_CLKREF  in  1  initiator bus-activity hint; high = access cycle starting.
- SDRAM_WADDR  in  25  write word address; bits [AW-1:0] used, upper bits ignored.
- SDRAM_DIN  in  32  write data.
- SDRAM_BE  in  4  byte enables, active-high; bit n enables DIN[8n+7:8n].
- SDRAM_WE  in  1  write request level.
- SDRAM_WE_RDY  out  1  write path idle/complete.
- SDRAM_RD  in  1  read request level.
- SDRAM_RD_RDY  out  1  read path idle; DOUT valid while high after a read.
- SDRAM_RADDR  in  25  read word address; bits [AW-1:0] used.
- SDRAM_DOUT  out  32  read data.

Behaviour:
- Reset (SDRAM_RESn low at a clock edge):
  - RD_RDY=1, WE_RDY=1, DOUT=0, state IDLE.
  - Latency counter cleared; refresh counter cleared.
  - Array contents are not cleared.
  - Reset mid-operation aborts the access: a pending write is not committed; RD_RDY and WE_RDY return to 1 on the next cycle.
- States: IDLE, READ, WRITE, REFRESH.
- IDLE:
  - WE=1 and WE_RDY=1: capture WADDR/DIN/BE; WE_RDY=0 next cycle; go to WRITE; load counter with WR_LAT-1.
  - Else RD=1 and RD_RDY=1: capture RADDR; RD_RDY=0 next cycle; go to READ; load counter with RD_LAT-1.
  - WE and RD both high in the same cycle: write is accepted and RD is ignored. RD_RDY stays 1, so the initiator holds RD and it is accepted on the first IDLE cycle after the write.
- READ:
  - Counter decrements each cycle.
  - At 0: DOUT <= array[addr] and RD_RDY<=1 on the same edge; go to IDLE.
  - DOUT then holds until the next read completes; writes never change DOUT.
- WRITE:
  - Counter decrements each cycle.
  - At 0: array[addr] bytes with BE=1 are updated and the others are unchanged; WE_RDY<=1; go to IDLE.
  - BE=0000 completes normally with no change.
- Only one access is in flight at a time.
- During READ, WE_RDY stays 1 but a WE request is not accepted until IDLE; the same rule applies to RD_RDY during WRITE. The idle-side RDY stays high so the initiator's falling-edge detection is not triggered spuriously.
- A request is recognised only while its RDY is high, because the initiator gates RD/WE with RDY. RD/WE held high after accept is ignored until the access completes.
- Read-after-write to the same address returns the new data.
- Address wrap: bits above AW-1 are ignored, so addresses alias modulo 2**AW.
- RD_RDY/WE_RDY are registered outputs; DOUT is registered, with no combinational path from inputs.

Optional Feature:
- Macro: SDRAM_RESP_REFRESH_EN.
- Refresh counter, defined:
  - Counts SDRAM_CLK cycles up to REF_PERIOD-1, then sets ref_pend.
  - ref_pend is serviced from IDLE only when SDRAM_CLKREF=0 and no request is being accepted in that cycle.
  - While CLKREF=1 the refresh is deferred indefinitely and ref_pend holds.
- REFRESH state:
  - RD_RDY=0 and WE_RDY=0 for REF_CYCLES cycles, then both return to 1 and the state goes to IDLE.
  - ref_pend clears on entry; the counter restarts on entry.
  - Requests arriving during REFRESH are held off by RDY=0 and accepted in the following IDLE.
- Macro undefined: no refresh logic; ready lines drop only for accepted accesses.

Test Plan:
- After reset, RD=1 with RADDR=0x10 for one cycle; array[0x10]=0xDEADBEEF, RD_LAT=4 → RD_RDY low for cycles 1-3 after accept, high at cycle 4 with DOUT=0xDEADBEEF; DOUT holds for 20 idle cycles.
- WE=1, WADDR=0x20, DIN=0x11223344, BE=0101 over old 0xAABBCCDD → WE_RDY low 1 cycle, high at cycle 2; then a read of 0x20 returns 0xAA22CC44.
- WE and RD asserted together (WADDR=RADDR=0x30, DIN=0x5) with RD held → write completes first; read then accepted and returns 0x00000005.
- Write to 0x1_0040 with AW=16, then read 0x0040 → returns the written data (alias check).
- Reset asserted at READ cycle 2 → RD_RDY=1 and DOUT=0 next cycle; a write aborted at WRITE cycle 1 leaves the target word unchanged.
- SDRAM_RESP_REFRESH_EN, REF_PERIOD=20, REF_CYCLES=8: CLKREF held 1 from cycle 15 to 30 → no refresh until cycle 31; then both RDY low exactly 8 cycles; an RD raised during refresh is accepted on the first IDLE cycle.

Source files
------------

// File: rtl/sdram_resp_bram.sv
// SDRAM request responder backed by an internal 32-bit block-RAM array, with MiSTer-style RDY timing.
// Define SDRAM_RESP_REFRESH_EN to emulate periodic refresh stalls gated by SDRAM_CLKREF.
module sdram_resp_bram #(
    parameter int AW         = 16,
    parameter int RD_LAT     = 4,
    parameter int WR_LAT     = 2,
    parameter int REF_PERIOD = 780,
    parameter int REF_CYCLES = 8
) (
    input  logic        SDRAM_CLK,
    input  logic        SDRAM_RESn,
    input  logic        SDRAM_CLKREF,
    input  logic [24:0] SDRAM_WADDR,
    input  logic [31:0] SDRAM_DIN,
    input  logic [3:0]  SDRAM_BE,
    input  logic        SDRAM_WE,
    output logic        SDRAM_WE_RDY,
    input  logic        SDRAM_RD,
    output logic        SDRAM_RD_RDY,
    input  logic [24:0] SDRAM_RADDR,
    output logic [31:0] SDRAM_DOUT
);

    localparam int CW = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WRITE   = 2'd2,
        REFRESH = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_dec_s;
    logic            rd_rdy_q, rd_rdy_d;
    logic            we_rdy_q, we_rdy_d;
    logic [AW-1:0]   raddr_q, raddr_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [31:0]     din_q, din_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     dout_q;
    logic            rd_fire_s;
    logic            wr_fire_s;
    logic            unused_s;
`ifdef SDRAM_RESP_REFRESH_EN
    logic [31:0]     ref_cnt_q, ref_cnt_d;
    logic            ref_pend_q, ref_pend_d;
`endif

    logic [31:0] mem_array [0:(1<<AW)-1];

`ifdef SDRAM_RESP_REFRESH_EN
    assign unused_s = ^{SDRAM_WADDR[24:AW], SDRAM_RADDR[24:AW]};
`else
    assign unused_s = ^{SDRAM_CLKREF, SDRAM_WADDR[24:AW], SDRAM_RADDR[24:AW],
                        REF_PERIOD[0], REF_CYCLES[0]};
`endif

    // Next-state, latency counter, request capture and ready computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_rdy_d  = rd_rdy_q;
        we_rdy_d  = we_rdy_q;
        raddr_d   = raddr_q;
        waddr_d   = waddr_q;
        din_d     = din_q;
        be_d      = be_q;
        rd_fire_s = 1'b0;
        wr_fire_s = 1'b0;
        cnt_dec_s = cnt_q - {{(CW-1){1'b0}}, 1'b1};
`ifdef SDRAM_RESP_REFRESH_EN
        ref_cnt_d  = ref_cnt_q;
        ref_pend_d = ref_pend_q;
        if (!ref_pend_q) begin
            if (ref_cnt_q == 32'(REF_PERIOD - 1)) begin
                ref_pend_d = 1'b1;
                ref_cnt_d  = 32'd0;
            end else begin
                ref_cnt_d = ref_cnt_q + 32'd1;
            end
        end else begin
            ref_cnt_d = ref_cnt_q;
        end
`endif
        case (state_q)
            IDLE: begin
                // Write wins a same-cycle collision; the read stays pending because RD_RDY stays high.
                if (SDRAM_WE && we_rdy_q) begin
                    waddr_d  = SDRAM_WADDR[AW-1:0];
                    din_d    = SDRAM_DIN;
                    be_d     = SDRAM_BE;
                    we_rdy_d = 1'b0;
                    cnt_d    = CW'(WR_LAT - 1);
                    state_d  = WRITE;
                end else if (SDRAM_RD && rd_rdy_q) begin
                    raddr_d  = SDRAM_RADDR[AW-1:0];
                    rd_rdy_d = 1'b0;
                    cnt_d    = CW'(RD_LAT - 1);
                    state_d  = READ;
`ifdef SDRAM_RESP_REFRESH_EN
                end else if (ref_pend_q && !SDRAM_CLKREF) begin
                    rd_rdy_d   = 1'b0;
                    we_rdy_d   = 1'b0;
                    cnt_d      = CW'(REF_CYCLES);
                    ref_pend_d = 1'b0;
                    ref_cnt_d  = 32'd0;
                    state_d    = REFRESH;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                cnt_d = cnt_dec_s;
                if (cnt_dec_s == {CW{1'b0}}) begin
                    rd_fire_s = 1'b1;
                    rd_rdy_d  = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = READ;
                end
            end
            WRITE: begin
                cnt_d = cnt_dec_s;
                if (cnt_dec_s == {CW{1'b0}}) begin
                    wr_fire_s = SDRAM_RESn;
                    we_rdy_d  = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = WRITE;
                end
            end
`ifdef SDRAM_RESP_REFRESH_EN
            REFRESH: begin
                cnt_d = cnt_dec_s;
                if (cnt_dec_s == {CW{1'b0}}) begin
                    rd_rdy_d = 1'b1;
                    we_rdy_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d = REFRESH;
                end
            end
`endif
            default: begin
                rd_rdy_d = 1'b1;
                we_rdy_d = 1'b1;
                state_d  = IDLE;
            end
        endcase
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge SDRAM_CLK) begin
        if (!SDRAM_RESn) begin
            state_q  <= IDLE;
            cnt_q    <= {CW{1'b0}};
            rd_rdy_q <= 1'b1;
            we_rdy_q <= 1'b1;
            raddr_q  <= {AW{1'b0}};
            waddr_q  <= {AW{1'b0}};
            din_q    <= 32'd0;
            be_q     <= 4'd0;
`ifdef SDRAM_RESP_REFRESH_EN
            ref_cnt_q  <= 32'd0;
            ref_pend_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_rdy_q <= rd_rdy_d;
            we_rdy_q <= we_rdy_d;
            raddr_q  <= raddr_d;
            waddr_q  <= waddr_d;
            din_q    <= din_d;
            be_q     <= be_d;
`ifdef SDRAM_RESP_REFRESH_EN
            ref_cnt_q  <= ref_cnt_d;
            ref_pend_q <= ref_pend_d;
`endif
        end
    end

    // Byte-enabled array write at write completion; contents survive reset.
    always_ff @(posedge SDRAM_CLK) begin
        if (wr_fire_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem_array[waddr_q][8*i +: 8] <= din_q[8*i +: 8];
                end
            end
        end
    end

    // Registered read port: DOUT only changes when a read completes.
    always_ff @(posedge SDRAM_CLK) begin
        if (!SDRAM_RESn) begin
            dout_q <= 32'd0;
        end else if (rd_fire_s) begin
            dout_q <= mem_array[raddr_q];
        end else begin
            dout_q <= dout_q;
        end
    end

    assign SDRAM_RD_RDY = rd_rdy_q;
    assign SDRAM_WE_RDY = we_rdy_q;
    assign SDRAM_DOUT   = dout_q;

endmodule

// File: tb/tb_sdram_resp_bram.sv
// Directed bench for sdram_resp_bram: read data checked by a scoreboard monitor, timing checked inline.
module tb_sdram_resp_bram;

    localparam int AW         = 16;
    localparam int RD_LAT     = 4;
    localparam int WR_LAT     = 2;
    localparam int REF_PERIOD = 20;
    localparam int REF_CYCLES = 8;

    logic        clk = 1'b0;
    logic        resn;
    logic        clkref;
    logic [24:0] waddr;
    logic [31:0] din;
    logic [3:0]  be;
    logic        we;
    logic        we_rdy;
    logic        rd;
    logic        rd_rdy;
    logic [24:0] raddr;
    logic [31:0] dout;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic        mon_en = 1'b1;
    logic        rd_rdy_prev = 1'b1;

    always #5 clk = ~clk;

    sdram_resp_bram #(
        .AW(AW), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT),
        .REF_PERIOD(REF_PERIOD), .REF_CYCLES(REF_CYCLES)
    ) dut (
        .SDRAM_CLK   (clk),
        .SDRAM_RESn  (resn),
        .SDRAM_CLKREF(clkref),
        .SDRAM_WADDR (waddr),
        .SDRAM_DIN   (din),
        .SDRAM_BE    (be),
        .SDRAM_WE    (we),
        .SDRAM_WE_RDY(we_rdy),
        .SDRAM_RD    (rd),
        .SDRAM_RD_RDY(rd_rdy),
        .SDRAM_RADDR (raddr),
        .SDRAM_DOUT  (dout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: each RD_RDY rising edge presents a read result (or a reset-cleared DOUT).
    always @(negedge clk) begin
        if (mon_en && rd_rdy === 1'b1 && rd_rdy_prev === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got completion with dout 0x%08h, want none", dout);
            end else begin
                chk("rd_data", dout, exp_q.pop_front());
            end
        end
        rd_rdy_prev = rd_rdy;
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(rd_rdy === 1'b1 && we_rdy === 1'b1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk(name, 32'(n), 32'd0);
    endtask

    task automatic do_write(input logic [24:0] a, input logic [31:0] d, input logic [3:0] b,
                            output int low);
        wait_idle("wr_idle_timeout");
        waddr = a; din = d; be = b; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
        low = 0;
        while (we_rdy !== 1'b1 && low < 50) begin
            low++;
            @(negedge clk);
        end
    endtask

    task automatic do_read(input logic [24:0] a, input logic [31:0] e, output int low);
        wait_idle("rd_idle_timeout");
        exp_q.push_back(e);
        raddr = a; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        low = 0;
        while (rd_rdy !== 1'b1 && low < 50) begin
            low++;
            @(negedge clk);
        end
    endtask

    initial begin
        int low;
        int bad;
        resn = 1'b0; clkref = 1'b1; waddr = '0; din = '0; be = '0;
        we = 1'b0; rd = 1'b0; raddr = '0;
        repeat (3) @(negedge clk);
        chk("rst_rd_rdy", {31'd0, rd_rdy}, 32'd1);
        chk("rst_we_rdy", {31'd0, we_rdy}, 32'd1);
        chk("rst_dout", dout, 32'd0);
        resn = 1'b1;
        @(negedge clk);

        // Read latency and DOUT hold
        do_write(25'h10, 32'hDEADBEEF, 4'hF, low);
        do_read(25'h10, 32'hDEADBEEF, low);
        chk("rd_lat", 32'(low), 32'd3);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (dout !== 32'hDEADBEEF) bad++;
        end
        chk("dout_hold", 32'(bad), 32'd0);

        // Byte-enable merge and write latency
        do_write(25'h20, 32'hAABBCCDD, 4'hF, low);
        do_write(25'h20, 32'h11223344, 4'b0101, low);
        chk("wr_lat", 32'(low), 32'd1);
        do_read(25'h20, 32'hAA22CC44, low);

        // BE=0000 leaves the word untouched
        do_write(25'h20, 32'hFFFFFFFF, 4'b0000, low);
        chk("wr_lat_be0", 32'(low), 32'd1);
        do_read(25'h20, 32'hAA22CC44, low);

        // Simultaneous WE and RD: write first, held RD accepted after
        wait_idle("both_idle_timeout");
        waddr = 25'h30; raddr = 25'h30; din = 32'h5; be = 4'hF;
        we = 1'b1; rd = 1'b1;
        exp_q.push_back(32'h5);
        @(negedge clk);
        we = 1'b0;
        chk("both_write_first", {30'd0, we_rdy, rd_rdy}, 32'd1);
        low = 0;
        while (rd_rdy !== 1'b0 && low < 50) begin
            @(negedge clk);
            low++;
        end
        rd = 1'b0;
        chk("both_rd_accept_delay", 32'(low), 32'd2);

        // Address alias modulo 2**AW
        do_write(25'h1_0040, 32'hCAFEF00D, 4'hF, low);
        do_read(25'h0040, 32'hCAFEF00D, low);

        // Reset during READ cycle 2: RD_RDY back high, DOUT cleared
        wait_idle("rst_rd_idle_timeout");
        exp_q.push_back(32'h0);
        raddr = 25'h10; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
        resn = 1'b0;
        @(negedge clk);
        chk("rst_mid_read_rdy", {31'd0, rd_rdy}, 32'd1);
        resn = 1'b1;

        // Reset during WRITE cycle 1 aborts the write
        do_write(25'h60, 32'h01020304, 4'hF, low);
        wait_idle("rst_wr_idle_timeout");
        waddr = 25'h60; din = 32'hFFFFFFFF; be = 4'hF; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
        resn = 1'b0;
        @(negedge clk);
        chk("rst_mid_write_rdy", {31'd0, we_rdy}, 32'd1);
        resn = 1'b1;
        do_read(25'h60, 32'h01020304, low);
        wait_idle("final_idle_timeout");
        @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

`ifdef SDRAM_RESP_REFRESH_EN
        // Refresh deferred while CLKREF=1, then exactly REF_CYCLES of stall
        mon_en = 1'b0;
        clkref = 1'b0;
        resn = 1'b0;
        repeat (2) @(negedge clk);
        resn = 1'b1;
        repeat (15) @(negedge clk);
        clkref = 1'b1;
        bad = 0;
        repeat (16) begin
            @(negedge clk);
            if (rd_rdy !== 1'b1 || we_rdy !== 1'b1) bad++;
        end
        chk("ref_deferred", 32'(bad), 32'd0);
        clkref = 1'b0;
        @(negedge clk);
        chk("ref_start", {30'd0, rd_rdy, we_rdy}, 32'd0);
        low = 0;
        while (rd_rdy === 1'b0 && we_rdy === 1'b0 && low < 50) begin
            low++;
            if (low == 3) begin
                raddr = 25'h10;
                rd = 1'b1;
            end
            @(negedge clk);
        end
        chk("ref_len", 32'(low), 32'(REF_CYCLES));
        clkref = 1'b1;
        @(negedge clk);
        chk("ref_rd_accept", {31'd0, rd_rdy}, 32'd0);
        rd = 1'b0;
        wait_idle("ref_rd_idle_timeout");
        chk("ref_rd_data", dout, 32'hDEADBEEF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
